// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding-mux selects and FSM states.
package hazard_pkg;
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } hz_state_e;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-register and hazard-control signals between the datapath and the hazard unit.
// master = datapath side (drives stage info), slave = hazard_ctrl_unit.
interface hazard_ctrl_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic                  id_use_rs, id_use_rt, id_branch, id_redirect;
   logic                  ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
   logic                  mdu_start, mdu_done;
   logic                  pc_load, if_id_enable, if_id_flush;
   logic                  id_ex_enable, id_ex_bubble, ex_mem_bubble;
   logic [1:0]            fwd_a_sel, fwd_b_sel;
   logic                  id_fwd_a_sel, id_fwd_b_sel;
   logic [CNT_W-1:0]      stall_cnt, flush_cnt;

   modport master (
      output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
      output id_use_rs, id_use_rt, id_branch, id_redirect,
      output ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite,
      output mdu_start, mdu_done,
      input  pc_load, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_bubble,
      input  fwd_a_sel, fwd_b_sel, id_fwd_a_sel, id_fwd_b_sel, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
      input  id_use_rs, id_use_rt, id_branch, id_redirect,
      input  ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite,
      input  mdu_start, mdu_done,
      output pc_load, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_bubble,
      output fwd_a_sel, fwd_b_sel, id_fwd_a_sel, id_fwd_b_sel, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones; result visible one cycle later.
// Synchronous clear takes priority over inc; no backpressure.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (clear) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign count = cnt_q;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: stalls, flushes and forwarding selects are combinational
// (same cycle); only the MDU state and the perf counters are registered.
import hazard_pkg::*;

module hazard_ctrl_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16,
   parameter int MDU_EN     = 1
) (
   input logic               clk,
   input logic               reset,
   hazard_ctrl_unit_if.slave hif
);
   hz_state_e state_d, state_q;
   logic mdu_go, mdu_fin, mdu_hold;
   logic hit_ex, hit_mem, pipe_stall, mem_fwd_ok, wb_fwd_ok;
   logic pc_load, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_bubble;

   // Register 0 is hardwired zero, so it can never carry a dependency.
   function automatic logic src_hit(input logic use_x, input logic [REG_ADDR_W-1:0] x,
                                    input logic [REG_ADDR_W-1:0] r);
      return use_x && (r != '0) && (x == r);
   endfunction

   function automatic logic [1:0] ex_fwd(input logic [REG_ADDR_W-1:0] src);
      if (mem_fwd_ok && (hif.mem_rd == src))     return FWD_MEM;
      else if (wb_fwd_ok && (hif.wb_rd == src))  return FWD_WB;
      else                                       return FWD_RF;
   endfunction

   always_comb begin
      mdu_go  = (MDU_EN != 0) && hif.mdu_start && !hif.mdu_done;
      mdu_fin = (MDU_EN != 0) && hif.mdu_done;
      state_d = state_q;
      case (state_q)
         RUN:      if (mdu_go)  state_d = MDU_BUSY;
         MDU_BUSY: if (mdu_fin) state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   always_comb begin
      mdu_hold   = ((MDU_EN != 0) && (state_q == MDU_BUSY)) || mdu_go;
      hit_ex     = src_hit(hif.id_use_rs, hif.id_rs, hif.ex_rd)
                 | src_hit(hif.id_use_rt, hif.id_rt, hif.ex_rd);
      hit_mem    = src_hit(hif.id_use_rs, hif.id_rs, hif.mem_rd)
                 | src_hit(hif.id_use_rt, hif.id_rt, hif.mem_rd);
      // A branch one behind a load stalls twice: first on EX, then on MEM.
      pipe_stall = (hif.ex_memread && hif.ex_regwrite && hit_ex)
                 | (hif.id_branch && hif.ex_regwrite && hit_ex)
                 | (hif.id_branch && hif.mem_memread && hit_mem);

      pc_load       = 1'b1;
      if_id_enable  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_enable  = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      if (mdu_hold) begin
         pc_load       = 1'b0;
         if_id_enable  = 1'b0;
         id_ex_enable  = 1'b0;
         ex_mem_bubble = 1'b1;
      end else if (pipe_stall) begin
         pc_load       = 1'b0;
         if_id_enable  = 1'b0;
         id_ex_bubble  = 1'b1;
      end else begin
         if_id_flush   = hif.id_redirect;
      end
   end

   // A load in MEM has no ALU result yet, so it is never a forwarding source.
   assign mem_fwd_ok = hif.mem_regwrite && !hif.mem_memread && (hif.mem_rd != '0);
   assign wb_fwd_ok  = hif.wb_regwrite && (hif.wb_rd != '0);

   assign hif.fwd_a_sel     = ex_fwd(hif.ex_rs);
   assign hif.fwd_b_sel     = ex_fwd(hif.ex_rt);
   assign hif.id_fwd_a_sel  = hif.mem_regwrite && !hif.mem_memread
                            && src_hit(hif.id_use_rs, hif.id_rs, hif.mem_rd);
   assign hif.id_fwd_b_sel  = hif.mem_regwrite && !hif.mem_memread
                            && src_hit(hif.id_use_rt, hif.id_rt, hif.mem_rd);
   assign hif.pc_load       = pc_load;
   assign hif.if_id_enable  = if_id_enable;
   assign hif.if_id_flush   = if_id_flush;
   assign hif.id_ex_enable  = id_ex_enable;
   assign hif.id_ex_bubble  = id_ex_bubble;
   assign hif.ex_mem_bubble = ex_mem_bubble;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (!pc_load),
      .count (hif.stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (if_id_flush),
      .count (hif.flush_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default build plus a CNT_W=3, MDU_EN=0 build on the same stimulus,
// each checked every cycle against a rule-level model and at key points against hand-computed values.
module tb_hazard_ctrl_unit;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic id_use_rs, id_use_rt, id_branch, id_redirect;
   logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
   logic mdu_start, mdu_done;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) hif ();
   hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(3))  hif3 ();

   hazard_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(16), .MDU_EN(1)) dut  (.clk(clk), .reset(reset), .hif(hif));
   hazard_ctrl_unit #(.REG_ADDR_W(5), .CNT_W(3),  .MDU_EN(0)) dut3 (.clk(clk), .reset(reset), .hif(hif3));

   assign hif.id_rs = id_rs;             assign hif3.id_rs = id_rs;
   assign hif.id_rt = id_rt;             assign hif3.id_rt = id_rt;
   assign hif.ex_rs = ex_rs;             assign hif3.ex_rs = ex_rs;
   assign hif.ex_rt = ex_rt;             assign hif3.ex_rt = ex_rt;
   assign hif.ex_rd = ex_rd;             assign hif3.ex_rd = ex_rd;
   assign hif.mem_rd = mem_rd;           assign hif3.mem_rd = mem_rd;
   assign hif.wb_rd = wb_rd;             assign hif3.wb_rd = wb_rd;
   assign hif.id_use_rs = id_use_rs;     assign hif3.id_use_rs = id_use_rs;
   assign hif.id_use_rt = id_use_rt;     assign hif3.id_use_rt = id_use_rt;
   assign hif.id_branch = id_branch;     assign hif3.id_branch = id_branch;
   assign hif.id_redirect = id_redirect; assign hif3.id_redirect = id_redirect;
   assign hif.ex_regwrite = ex_regwrite; assign hif3.ex_regwrite = ex_regwrite;
   assign hif.ex_memread = ex_memread;   assign hif3.ex_memread = ex_memread;
   assign hif.mem_regwrite = mem_regwrite; assign hif3.mem_regwrite = mem_regwrite;
   assign hif.mem_memread = mem_memread; assign hif3.mem_memread = mem_memread;
   assign hif.wb_regwrite = wb_regwrite; assign hif3.wb_regwrite = wb_regwrite;
   assign hif.mdu_start = mdu_start;     assign hif3.mdu_start = mdu_start;
   assign hif.mdu_done = mdu_done;       assign hif3.mdu_done = mdu_done;

   typedef struct packed {
      logic       pc_load, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_bubble;
      logic [1:0] fa, fb;
      logic       ifa, ifb;
   } exp_t;

   // Model state: whether the MDU is mid-operation, and counter values.
   bit busy_m = 1'b0;
   int stall_m = 0, flush_m = 0, stall3_m = 0, flush3_m = 0;

   function automatic logic [1:0] model_ex_fwd(input int r);
      if (r != 0 && mem_regwrite && !mem_memread && r == int'(mem_rd)) return 2'd1;
      if (r != 0 && wb_regwrite && r == int'(wb_rd))                   return 2'd2;
      return 2'd0;
   endfunction

   function automatic exp_t model(input bit busy, input bit mdu_en);
      exp_t e;
      int   src [2];
      bit   used[2];
      bit   dep_ex = 0, dep_mem = 0, hold, stall;
      src[0] = int'(id_rs); src[1] = int'(id_rt);
      used[0] = id_use_rs;  used[1] = id_use_rt;
      for (int i = 0; i < 2; i++) begin
         if (used[i] && src[i] != 0) begin
            if (src[i] == int'(ex_rd))  dep_ex = 1;
            if (src[i] == int'(mem_rd)) dep_mem = 1;
         end
      end
      hold  = mdu_en && (busy || (mdu_start && !mdu_done));
      stall = hold || (dep_ex && ex_regwrite && (ex_memread || id_branch))
                   || (dep_mem && id_branch && mem_memread);
      e.pc_load       = !stall;
      e.if_id_enable  = !stall;
      e.if_id_flush   = id_redirect && !stall;
      e.id_ex_enable  = !hold;
      e.id_ex_bubble  = stall && !hold;
      e.ex_mem_bubble = hold;
      e.fa  = model_ex_fwd(int'(ex_rs));
      e.fb  = model_ex_fwd(int'(ex_rt));
      e.ifa = mem_regwrite && !mem_memread && id_use_rs && id_rs != 0 && id_rs == mem_rd;
      e.ifb = mem_regwrite && !mem_memread && id_use_rt && id_rt != 0 && id_rt == mem_rd;
      return e;
   endfunction

   function automatic int sat_inc(input int v, input int w);
      return (v >= (1 << w) - 1) ? v : v + 1;
   endfunction

   always @(posedge clk) begin
      exp_t e, e3;
      e  = model(busy_m, 1'b1);
      e3 = model(1'b0, 1'b0);
      if (reset) begin
         busy_m = 0; stall_m = 0; flush_m = 0; stall3_m = 0; flush3_m = 0;
      end else begin
         if (!e.pc_load)     stall_m  = sat_inc(stall_m, 16);
         if (e.if_id_flush)  flush_m  = sat_inc(flush_m, 16);
         if (!e3.pc_load)    stall3_m = sat_inc(stall3_m, 3);
         if (e3.if_id_flush) flush3_m = sat_inc(flush3_m, 3);
         busy_m = busy_m ? !mdu_done : (mdu_start && !mdu_done);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input exp_t a, input exp_t e,
                      input int as, input int es, input int af, input int ef);
      check({tag, ".pc_load"},       a.pc_load,       e.pc_load);
      check({tag, ".if_id_enable"},  a.if_id_enable,  e.if_id_enable);
      check({tag, ".if_id_flush"},   a.if_id_flush,   e.if_id_flush);
      check({tag, ".id_ex_enable"},  a.id_ex_enable,  e.id_ex_enable);
      check({tag, ".id_ex_bubble"},  a.id_ex_bubble,  e.id_ex_bubble);
      check({tag, ".ex_mem_bubble"}, a.ex_mem_bubble, e.ex_mem_bubble);
      check({tag, ".fwd_a_sel"},     a.fa,            e.fa);
      check({tag, ".fwd_b_sel"},     a.fb,            e.fb);
      check({tag, ".id_fwd_a_sel"},  a.ifa,           e.ifa);
      check({tag, ".id_fwd_b_sel"},  a.ifb,           e.ifb);
      check({tag, ".stall_cnt"},     as,              es);
      check({tag, ".flush_cnt"},     af,              ef);
   endtask

   always @(negedge clk) begin
      exp_t a, a3;
      if (chk_en) begin
         a  = '{hif.pc_load, hif.if_id_enable, hif.if_id_flush, hif.id_ex_enable,
                hif.id_ex_bubble, hif.ex_mem_bubble, hif.fwd_a_sel, hif.fwd_b_sel,
                hif.id_fwd_a_sel, hif.id_fwd_b_sel};
         a3 = '{hif3.pc_load, hif3.if_id_enable, hif3.if_id_flush, hif3.id_ex_enable,
                hif3.id_ex_bubble, hif3.ex_mem_bubble, hif3.fwd_a_sel, hif3.fwd_b_sel,
                hif3.id_fwd_a_sel, hif3.id_fwd_b_sel};
         cmp("model", a, model(busy_m, 1'b1), int'(hif.stall_cnt), stall_m,
             int'(hif.flush_cnt), flush_m);
         cmp("model3", a3, model(1'b0, 1'b0), int'(hif3.stall_cnt), stall3_m,
             int'(hif3.flush_cnt), flush3_m);
      end
   end

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      id_use_rs = 0; id_use_rt = 0; id_branch = 0; id_redirect = 0;
      ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0; wb_regwrite = 0;
      mdu_start = 0; mdu_done = 0;
   endtask

   task automatic next();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic load_use_2();
      ex_rd = 2; ex_memread = 1; ex_regwrite = 1;
      id_rs = 2; id_use_rs = 1; id_rt = 4; id_use_rt = 1;
   endtask

   initial begin
      idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk_en = 1;
      settle();
      check("rst.pc_load", hif.pc_load, 1);
      check("rst.id_ex_enable", hif.id_ex_enable, 1);
      check("rst.stall_cnt", int'(hif.stall_cnt), 0);

      // lw $2 in EX, add $3,$2,$4 in ID
      next(); load_use_2(); settle();
      check("lu.pc_load", hif.pc_load, 0);
      check("lu.if_id_enable", hif.if_id_enable, 0);
      check("lu.id_ex_bubble", hif.id_ex_bubble, 1);
      check("lu.id_ex_enable", hif.id_ex_enable, 1);
      next(); ex_rs = 2; ex_rt = 4; wb_rd = 2; wb_regwrite = 1; settle();
      check("lu.fwd_a_sel", hif.fwd_a_sel, 2);
      check("lu.fwd_b_sel", hif.fwd_b_sel, 0);
      check("lu.stall_cnt", int'(hif.stall_cnt), 1);

      // lw $5 then beq $5,$0: two stalls, redirect deferred then flushed
      next(); ex_rd = 5; ex_memread = 1; ex_regwrite = 1;
      id_branch = 1; id_rs = 5; id_use_rs = 1; id_use_rt = 1; settle();
      check("br.stall1", hif.pc_load, 0);
      next(); mem_rd = 5; mem_memread = 1; mem_regwrite = 1;
      id_branch = 1; id_rs = 5; id_use_rs = 1; id_use_rt = 1; id_redirect = 1; settle();
      check("br.stall2", hif.pc_load, 0);
      check("br.deferred_flush", hif.if_id_flush, 0);
      check("br.no_id_fwd_load", hif.id_fwd_a_sel, 0);
      next(); wb_rd = 5; wb_regwrite = 1;
      id_branch = 1; id_rs = 5; id_use_rs = 1; id_use_rt = 1; id_redirect = 1; settle();
      check("br.flush", hif.if_id_flush, 1);
      check("br.pc_load", hif.pc_load, 1);
      next(); settle();
      check("br.stall_cnt", int'(hif.stall_cnt), 3);
      check("br.flush_cnt", int'(hif.flush_cnt), 1);

      // forwarding priority and r0 immunity
      next(); mem_rd = 7; mem_regwrite = 1; wb_rd = 7; wb_regwrite = 1; ex_rs = 7; ex_rt = 7; settle();
      check("fwd.mem_beats_wb_a", hif.fwd_a_sel, 1);
      check("fwd.mem_beats_wb_b", hif.fwd_b_sel, 1);
      next(); mem_rd = 7; mem_regwrite = 1; mem_memread = 1; wb_rd = 7; wb_regwrite = 1;
      ex_rs = 7; ex_rt = 3; settle();
      check("fwd.load_in_mem_a", hif.fwd_a_sel, 2);
      check("fwd.none_b", hif.fwd_b_sel, 0);
      next(); ex_rd = 0; ex_memread = 1; ex_regwrite = 1; id_rs = 0; id_use_rs = 1;
      mem_rd = 3; mem_regwrite = 1; id_rt = 3; id_use_rt = 1; settle();
      check("r0.no_stall", hif.pc_load, 1);
      check("idfwd.b", hif.id_fwd_b_sel, 1);
      check("idfwd.a", hif.id_fwd_a_sel, 0);

      // MDU op: start + 3 busy cycles, done on the 4th
      next(); mdu_start = 1; settle();
      check("mdu.t0.pc_load", hif.pc_load, 0);
      check("mdu.t0.ex_mem_bubble", hif.ex_mem_bubble, 1);
      check("mdu.t0.id_ex_enable", hif.id_ex_enable, 0);
      check("mdu.disabled.pc_load", hif3.pc_load, 1);
      next(); load_use_2(); settle();
      check("mdu.t1.id_ex_bubble", hif.id_ex_bubble, 0);
      check("mdu.t1.pc_load", hif.pc_load, 0);
      next(); id_redirect = 1; settle();
      check("mdu.t2.flush", hif.if_id_flush, 0);
      next(); mdu_done = 1; settle();
      check("mdu.t3.pc_load", hif.pc_load, 0);
      next(); settle();
      check("mdu.t4.pc_load", hif.pc_load, 1);
      check("mdu.t4.id_ex_enable", hif.id_ex_enable, 1);
      check("mdu.stall_cnt", int'(hif.stall_cnt), 7);
      check("mdu.disabled.stall_cnt", int'(hif3.stall_cnt), 4);

      // start and done together: no stall
      next(); mdu_start = 1; mdu_done = 1; settle();
      check("mdu.same.pc_load", hif.pc_load, 1);
      next(); settle();
      check("mdu.same.after", hif.ex_mem_bubble, 0);

      // reset mid-MDU
      next(); mdu_start = 1;
      next(); settle();
      check("rstmdu.busy", hif.pc_load, 0);
      next(); reset = 1; settle();
      next(); reset = 0; settle();
      check("rstmdu.pc_load", hif.pc_load, 1);
      check("rstmdu.if_id_enable", hif.if_id_enable, 1);
      check("rstmdu.id_ex_enable", hif.id_ex_enable, 1);
      check("rstmdu.stall_cnt", int'(hif.stall_cnt), 0);
      check("rstmdu.flush_cnt", int'(hif.flush_cnt), 0);

      // saturation of the 3-bit counter
      for (int i = 0; i < 9; i++) begin
         next(); load_use_2();
      end
      next(); settle();
      check("sat.cnt3", int'(hif3.stall_cnt), 7);
      check("sat.cnt16", int'(hif.stall_cnt), 9);

      next();
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
